// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared sizes and types for the async_fifo read-side drain stage
package fifo_drain_pkg;

  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// rtl/drain_skid_buf.sv - 3-entry circular buffer with push/pop/flush and registered head data
module drain_skid_buf
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output occ_t             occ,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush overrides both ends, so a same-cycle push or pop never lands.
  assign do_push   = push && !flush;
  assign do_pop    = pop && !flush && (occ != occ_t'(0));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - credit-based async_fifo read drain onto a valid/ready stream
module fifo_rd_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic                 fifo_error,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 flush,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 err_sticky
);

  occ_t       occ;
  logic       inflight;
  logic [2:0] credit_used;
  logic       accept;

  // Entries held plus the beat already requested must leave room for this read.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en  = rst_n && !fifo_empty && !flush && (credit_used <= 3'd2);
  assign m_valid     = (occ != occ_t'(0));
  assign accept      = m_valid && m_ready;

  drain_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (rd_clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (accept),
    .flush    (flush),
    .occ      (occ),
    .head_data(m_data)
  );

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)      rd_count <= '0;
    else if (clr)    rd_count <= '0;
    else if (accept) rd_count <= rd_count + CNT_WIDTH'(1);
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n)          err_sticky <= 1'b0;
    else if (fifo_error) err_sticky <= 1'b1;
    else if (clr)        err_sticky <= 1'b0;
  end

endmodule
